// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus memory-mapped GPIO, timer/compare and write-fault capture
module dmem_mmio #(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       a,
    input  logic [31:0]       wd,
    input  logic              we,
    output logic [31:0]       rd,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              bus_err
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]       mem [MEM_WORDS];
    logic [GPIO_W-1:0] gpo_q, gpo_d, sync1_q, sync2_q;
    logic [31:0]       cnt_q, cnt_d, cmp_q, cmp_d, err_q, err_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              stat_q, stat_d, berr_q;
    logic              is_ram, is_io, fault, ram_we, io_we, hit;
    logic [7:0]        off;
    logic [31:0]       io_rd;

    // address decode, fault detection and combinational read mux
    always_comb begin
        is_ram = a < 32'(MEM_WORDS * 4);
        is_io  = a[31:8] == IO_BASE[31:8];
        off    = {a[7:2], 2'b00};
        fault  = we && (a[1:0] != 2'b00 || !(is_ram || is_io) ||
                 (is_io && (off > 8'h18 || off == 8'h04 || off == 8'h18)));
        ram_we = we && !fault && is_ram;
        io_we  = we && !fault && is_io;
        io_rd  = off == 8'h00 ? 32'({gpo_q}) :
                 off == 8'h04 ? 32'({sync2_q}) :
                 off == 8'h08 ? cnt_q :
                 off == 8'h0C ? cmp_q :
                 off == 8'h10 ? {30'b0, ctrl_q} :
                 off == 8'h14 ? {31'b0, stat_q} :
                 off == 8'h18 ? err_q : 32'b0;
        rd     = is_ram ? mem[a[AW+1:2]] : is_io ? io_rd : 32'b0;
    end

    // register next-state: software writes beat timer increment, hardware match beats W1C
    always_comb begin
        hit    = ctrl_q[0] && cnt_q == cmp_q;
        gpo_d  = io_we && off == 8'h00 ? wd[GPIO_W-1:0] : gpo_q;
        cmp_d  = io_we && off == 8'h0C ? wd : cmp_q;
        ctrl_d = io_we && off == 8'h10 ? wd[1:0] : ctrl_q;
        cnt_d  = io_we && off == 8'h08 ? wd :
                 !ctrl_q[0]            ? cnt_q :
                 hit && ctrl_q[1]      ? 32'b0 : cnt_q + 32'd1;
        stat_d = hit || (stat_q && !(io_we && off == 8'h14 && wd[0]));
        err_d  = fault ? a : err_q;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            gpo_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            ctrl_q  <= '0;
            stat_q  <= 1'b0;
            err_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            gpo_q   <= gpo_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            stat_q  <= stat_d;
            err_q   <= err_d;
            berr_q  <= fault;
        end
    end

    // RAM write port; contents survive reset but a write under reset is dropped
    always_ff @(posedge clk) begin
        if (ram_we && !reset) mem[a[AW+1:2]] <= wd;
    end

    assign gpio_out  = gpo_q;
    assign timer_irq = stat_q;
    assign bus_err   = berr_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed stimulus checked against a behavioural model every cycle
module tb_dmem_mmio;
    localparam logic [31:0] IO = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset, we;
    logic [31:0] a, wd, rd;
    logic [7:0]  gpio_in, gpio_out;
    logic        timer_irq, bus_err;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 1'b0;

    logic [31:0] m_mem [64];
    bit          m_val [64];
    logic [7:0]  m_gpo, m_s1, m_s2;
    logic [31:0] m_cnt, m_cmp, m_err;
    logic [1:0]  m_ctrl;
    logic        m_stat, m_berr;

    dmem_mmio dut (
        .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .rd(rd),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {known, value} of what a read at addr must return from the model state
    function automatic logic [32:0] model_rd(input logic [31:0] addr);
        if (addr < 32'd256) return {m_val[addr[7:2]], m_mem[addr[7:2]]};
        if (addr[31:8] != IO[31:8]) return {1'b1, 32'h0};
        case ({addr[7:2], 2'b00})
            8'h00:   return {1'b1, 24'h0, m_gpo};
            8'h04:   return {1'b1, 24'h0, m_s2};
            8'h08:   return {1'b1, m_cnt};
            8'h0C:   return {1'b1, m_cmp};
            8'h10:   return {1'b1, 30'h0, m_ctrl};
            8'h14:   return {1'b1, 31'h0, m_stat};
            8'h18:   return {1'b1, m_err};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // model: apply the cycle's transaction and timer rules at each rising edge
    always @(posedge clk) begin
        automatic logic [7:0] o = a[7:0];
        automatic bit ram = a < 32'd256;
        automatic bit io = a[31:8] == IO[31:8];
        automatic bit bad = we && (a[1:0] != 0 || !(ram || io) ||
                            (io && (o > 8'h18 || o == 8'h04 || o == 8'h18)));
        automatic bit match = m_ctrl[0] && m_cnt == m_cmp;
        if (reset) begin
            m_gpo = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
            m_ctrl = 0; m_stat = 0; m_err = 0; m_berr = 0;
        end else begin
            if (m_ctrl[0]) m_cnt = (match && m_ctrl[1]) ? 32'h0 : m_cnt + 1;
            if (match) m_stat = 1;
            if (we && !bad && ram) begin
                m_mem[a[7:2]] = wd;
                m_val[a[7:2]] = 1;
            end
            if (we && !bad && io) begin
                case (o)
                    8'h00: m_gpo = wd[7:0];
                    8'h08: m_cnt = wd;
                    8'h0C: m_cmp = wd;
                    8'h10: m_ctrl = wd[1:0];
                    8'h14: if (wd[0]) m_stat = match;
                    default: ;
                endcase
            end
            if (bad) m_err = a;
            m_berr = bad;
            m_s2 = m_s1;
            m_s1 = gpio_in;
        end
    end

    // compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            automatic logic [32:0] e = model_rd(a);
            if (e[32]) chk("model_rd", rd, e[31:0]);
            chk("model_gpio_out", {24'h0, gpio_out}, {24'h0, m_gpo});
            chk("model_irq", {31'h0, timer_irq}, {31'h0, m_stat});
            chk("model_bus_err", {31'h0, bus_err}, {31'h0, m_berr});
        end
    end

    task automatic step(input logic [31:0] aa, input logic [31:0] dd, input logic ww);
        @(posedge clk);
        #1;
        a = aa; wd = dd; we = ww;
        #3;
    endtask

    logic [31:0] cseq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    logic        iseq [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        reset = 1; a = 0; wd = 0; we = 0; gpio_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;
        chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        step(IO + 32'h0C, 0, 0);
        chk("rst_cmp", rd, 32'hFFFF_FFFF);
        reset = 0;
        // T1 RAM write then aligned and unaligned read
        step(32'h10, 32'h1234_5678, 1);
        step(32'h10, 0, 0);
        chk("t1_read", rd, 32'h1234_5678);
        step(32'h12, 0, 0);
        chk("t1_unaligned", rd, 32'h1234_5678);
        // T2 faulting writes
        step(32'h11, 32'hDEAD_BEEF, 1);
        step(32'h10, 0, 0);
        chk("t2_bus_err", {31'h0, bus_err}, 32'h1);
        chk("t2_ram_kept", rd, 32'h1234_5678);
        step(IO + 32'h18, 0, 0);
        chk("t2_err_addr", rd, 32'h11);
        chk("t2_pulse_end", {31'h0, bus_err}, 32'h0);
        step(32'h1000, 5, 1);
        step(32'h1000, 0, 0);
        chk("t2_unmapped_rd", rd, 32'h0);
        step(IO + 32'h04, 1, 1);
        step(IO + 32'h1C, 1, 1);
        step(IO + 32'h18, 0, 0);
        chk("t2_err_off1c", rd, 32'hFFFF_001C);
        step(32'hFC, 32'hCAFE, 1);
        step(32'h100, 1, 1);
        step(32'hFC, 0, 0);
        chk("t2_last_word", rd, 32'hCAFE);
        chk("t2_ram_end_err", {31'h0, bus_err}, 32'h1);
        // T3 autoreload timer sequence
        step(IO + 32'h08, 0, 1);
        step(IO + 32'h0C, 5, 1);
        step(IO + 32'h10, 32'hFFFF_FFF3, 1);
        for (int i = 0; i < 8; i++) begin
            step(IO + 32'h08, 0, 0);
            chk("t3_cnt", rd, cseq[i]);
            chk("t3_irq", {31'h0, timer_irq}, {31'h0, iseq[i]});
        end
        // T4 match beats simultaneous W1C; plain W1C clears
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt2", rd, 2);
        step(IO + 32'h10, 0, 0);
        chk("t4_ctrl", rd, 3);
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt4", rd, 4);
        step(IO + 32'h14, 1, 1);
        step(IO + 32'h14, 0, 0);
        chk("t4_stat_kept", rd, 1);
        step(IO + 32'h14, 1, 1);
        step(IO + 32'h14, 0, 0);
        chk("t4_stat_clr", rd, 0);
        chk("t4_irq_clr", {31'h0, timer_irq}, 32'h0);
        step(IO + 32'h08, 100, 1);
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt_wr", rd, 100);
        step(IO + 32'h10, 0, 1);
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt_last", rd, 102);
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt_hold", rd, 102);
        step(IO + 32'h08, 32'hFFFF_FFFF, 1);
        step(IO + 32'h10, 1, 1);
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt_max", rd, 32'hFFFF_FFFF);
        step(IO + 32'h08, 0, 0);
        chk("t4_cnt_wrap", rd, 0);
        step(IO + 32'h10, 0, 1);
        // T5 GPIO synchronizer latency and output width
        gpio_in = 8'hA5;
        step(IO + 32'h04, 0, 0);
        chk("t5_gpio_lat1", rd, 0);
        step(IO + 32'h04, 0, 0);
        chk("t5_gpio_lat2", rd, 32'hA5);
        step(IO, 32'h1FF, 1);
        step(IO, 0, 0);
        chk("t5_gpo_rd", rd, 32'hFF);
        chk("t5_gpo_pin", {24'h0, gpio_out}, 32'hFF);
        // T6 reset with pending state and a write in flight
        step(IO + 32'h08, 0, 1);
        step(IO + 32'h0C, 2, 1);
        step(IO + 32'h10, 1, 1);
        repeat (4) step(IO + 32'h14, 0, 0);
        chk("t6_irq_pre", {31'h0, timer_irq}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1; a = 32'h10; wd = 32'hBAD0_BAD0; we = 1;
        step(32'h10, 32'hBAD0_BAD0, 1);
        #1;
        we = 0;
        reset = 0;
        chk("t6_gpo", {24'h0, gpio_out}, 32'h0);
        chk("t6_irq", {31'h0, timer_irq}, 32'h0);
        chk("t6_bus_err", {31'h0, bus_err}, 32'h0);
        step(32'h10, 0, 0);
        chk("t6_ram_kept", rd, 32'h1234_5678);
        step(IO + 32'h08, 0, 0);
        chk("t6_cnt", rd, 0);
        step(IO + 32'h0C, 0, 0);
        chk("t6_cmp", rd, 32'hFFFF_FFFF);
        step(IO + 32'h18, 0, 0);
        chk("t6_err", rd, 0);
        step(IO + 32'h10, 0, 0);
        chk("t6_ctrl", rd, 0);
        step(0, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
